fb_pixel_sink: RTL and testbench
================================

# fb_pixel_sink

Receiving end of the line engine's pixel-write stream. Accepts `wr_valid`/`write_x_pos`/`write_y_pos` beats plus a colour, clips them to the 160x120 screen and converts them to linear framebuffer addresses. Drops back-to-back duplicate writes and buffers the rest in a FIFO. Drains to a shared framebuffer RAM write port that may be stalled by a grant, since scan-out owns the RAM part of the time. The line engine has no backpressure, so this block absorbs bursts and flags any loss.

## Interface
Parameters:
- `FIFO_DEPTH`, 16: FIFO entries; power of two, at least 4.
- `COLOR_W`, 3: pixel colour width.
- `VGA_WIDTH`, 160: visible columns.
- `VGA_HEIGHT`, 120: visible rows.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `wr_valid`  in  1  pixel beat valid this cycle; no ready, every beat must be taken.
- `write_x_pos`  in  8  pixel column, unsigned.
- `write_y_pos`  in  7  pixel row, unsigned.
- `pixel_color`  in  COLOR_W  colour, sampled with `wr_valid`.
- `fb_we`  out  1  FIFO head valid, i.e. write request.
- `fb_addr`  out  15  address of the head entry: y*VGA_WIDTH + x.
- `fb_wdata`  out  COLOR_W  colour of the head entry.
- `fb_grant`  in  1  RAM accepts the head this cycle when `fb_we` and `fb_grant` are both high.
- `clr_status`  in  1  synchronous clear of `overflow` and `clipped_count`.
- `busy`  out  1  pixel still in flight: stage-1 valid or FIFO non-empty.
- `overflow`  out  1  sticky; a pixel was lost because the FIFO was full.
- `clipped_count`  out  16  number of beats discarded as off-screen; saturates at 0xFFFF.

## Operation
- **Stage 1 (registered on `wr_valid`):**
  - Clip test: x >= VGA_WIDTH or y >= VGA_HEIGHT.
  - Address = (y<<7) + (y<<5) + x, computed in 15 bits with no overflow possible for on-screen pixels. Also latch colour.
  - Set `s1_valid` only if the beat is on-screen.
  - An off-screen beat increments `clipped_count` and nothing else.
- **Duplicate filter (stage 1 → FIFO):**
  - Drop the stage-1 entry if `last_valid` is set and its {addr,colour} equals the last pushed {addr,colour}.
  - A dropped duplicate does not affect the counters or `overflow`.
  - `last_valid` clears on reset only.
- **Push rules:**
  - Push when `s1_valid`, the entry is not a duplicate, and the FIFO is not full, or it is full but a pop occurs in the same cycle.
  - Otherwise the entry is lost and `overflow` is set.
  - Last-pushed {addr,colour} updates only on a successful push.
- **Pop:** occurs when `fb_we && fb_grant`.
  - `fb_addr`/`fb_wdata` always show the head entry and hold stable while `fb_we` is high without grant.
- **FIFO storage:** circular buffer, read/write pointers one bit wider than log2(FIFO_DEPTH).
  - Full when pointers differ only in the MSB; empty when equal.
  - Pointers wrap modulo 2*FIFO_DEPTH.
- **`clr_status`:** has priority over a clip or overflow event in the same cycle; that event is not recorded.
- **Reset (asynchronous, any time including mid-burst):**
  - FIFO emptied, `s1_valid`=0, `last_valid`=0.
  - `fb_we`=0, `fb_addr`=0, `fb_wdata`=0, `busy`=0, `overflow`=0, `clipped_count`=0.
  - In-flight pixels are discarded.

## Timing
- Beat sampled at edge E0 reaches stage 1. It is pushed at E1. `fb_we` is high in the cycle after E1 when the FIFO was empty: 2-cycle latency from `wr_valid` to `fb_we`.
- With `fb_grant` held high and a continuous stream, throughput is one pixel per clock and the FIFO never fills.
- The head is removed at the edge where `fb_we && fb_grant`. The next entry appears on `fb_addr`/`fb_wdata` in the same following cycle, with no bubble.
- `busy` falls in the cycle after the last pop, and only if `s1_valid` is 0.
- `overflow` and `clipped_count` update one edge after the causing event is in stage 1 (clip) or at push time (overflow).
- All outputs are registered or decoded from registers only; no combinational path from any input to any output.

## Test plan
- Reset, `fb_grant`=1, single beat x=5, y=3, colour=2 → exactly one `fb_we` pulse 2 cycles later, `fb_addr`=485, `fb_wdata`=2; `busy` high for 2 cycles.
- Beats (159,119) then (160,0) then (0,120) → one write at addr 19199; `clipped_count`=2; `overflow`=0.
- Same pixel (10,10,c=1) sent 4 consecutive cycles, then (10,10,c=4) → exactly two writes, both at addr 1610, colours 1 then 4.
- `fb_grant`=0, 20 distinct beats with FIFO_DEPTH=16 → `overflow`=1, 16 held. Grant released → 16 writes of the first 16 pixels in order at 1/cycle; `busy` drops after them.
- FIFO full with `fb_grant` pulsed high for one cycle while a new beat arrives → pop and push in the same cycle, no loss, `overflow` stays 0.
- `rst_n` low asynchronously mid-drain with 8 entries queued → `fb_we`=0 immediately, no further writes after release. `clr_status` asserted together with a clip event → `clipped_count`=0.

Source files
------------

// File: rtl/fb_pixel_sink.sv
// Pixel-write sink: clips beats to the screen, converts them to linear framebuffer addresses, drops repeated pixels, and queues them for a granted RAM port.
// Latency: 2 cycles from wr_valid to fb_we when the FIFO is empty; one pixel per clock while fb_grant is held high.
// Backpressure: the input cannot stall; when the FIFO is full and nothing pops, the pixel is dropped and overflow is set until cleared.
module fb_pixel_sink #(
    parameter int FIFO_DEPTH = 16,
    parameter int COLOR_W    = 3,
    parameter int VGA_WIDTH  = 160,
    parameter int VGA_HEIGHT = 120
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_valid,
    input  logic [7:0]         write_x_pos,
    input  logic [6:0]         write_y_pos,
    input  logic [COLOR_W-1:0] pixel_color,
    output logic               fb_we,
    output logic [14:0]        fb_addr,
    output logic [COLOR_W-1:0] fb_wdata,
    input  logic               fb_grant,
    input  logic               clr_status,
    output logic               busy,
    output logic               overflow,
    output logic [15:0]        clipped_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = 15 + COLOR_W;

    logic               s1_valid_q, s1_valid_d;
    logic               s1_clip_q, s1_clip_d;
    logic [14:0]        s1_addr_q, s1_addr_d;
    logic [COLOR_W-1:0] s1_color_q, s1_color_d;
    logic               last_valid_q, last_valid_d;
    logic [EW-1:0]      last_ent_q, last_ent_d;
    logic [AW:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic               overflow_q, overflow_d;
    logic [15:0]        clip_cnt_q, clip_cnt_d;
    logic [EW-1:0]      mem [FIFO_DEPTH];

    logic               in_bounds, empty, full, pop, dup, cand, push, lost;
    logic [14:0]        y_ext, beat_addr;
    logic [EW-1:0]      s1_ent, head;

    always_comb begin
        in_bounds = (32'(write_x_pos) < 32'(VGA_WIDTH)) && (32'(write_y_pos) < 32'(VGA_HEIGHT));
        y_ext     = {8'd0, write_y_pos};
        // y*160 as two shifts; cannot overflow 15 bits for on-screen rows
        beat_addr = (y_ext << 7) + (y_ext << 5) + {7'd0, write_x_pos};

        empty  = (wr_ptr_q == rd_ptr_q);
        full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop    = !empty && fb_grant;
        s1_ent = {s1_addr_q, s1_color_q};
        dup    = last_valid_q && (s1_ent == last_ent_q);
        cand   = s1_valid_q && !dup;
        push   = cand && (!full || pop);
        lost   = cand && !push;
        head   = mem[rd_ptr_q[AW-1:0]];

        s1_valid_d   = wr_valid && in_bounds;
        s1_clip_d    = wr_valid && !in_bounds;
        s1_addr_d    = wr_valid ? beat_addr : s1_addr_q;
        s1_color_d   = wr_valid ? pixel_color : s1_color_q;
        last_valid_d = last_valid_q || push;
        last_ent_d   = push ? s1_ent : last_ent_q;
        wr_ptr_d     = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d     = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;

        overflow_d = overflow_q;
        clip_cnt_d = clip_cnt_q;
        // a clear in the same cycle wins over a new clip or loss event
        if (clr_status) begin
            overflow_d = 1'b0;
            clip_cnt_d = '0;
        end else begin
            if (lost)
                overflow_d = 1'b1;
            if (s1_clip_q && clip_cnt_q != 16'hFFFF)
                clip_cnt_d = clip_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_clip_q    <= 1'b0;
            s1_addr_q    <= '0;
            s1_color_q   <= '0;
            last_valid_q <= 1'b0;
            last_ent_q   <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            overflow_q   <= 1'b0;
            clip_cnt_q   <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_clip_q    <= s1_clip_d;
            s1_addr_q    <= s1_addr_d;
            s1_color_q   <= s1_color_d;
            last_valid_q <= last_valid_d;
            last_ent_q   <= last_ent_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            overflow_q   <= overflow_d;
            clip_cnt_q   <= clip_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_q[AW-1:0]] <= s1_ent;
    end

    // head is masked while empty so the port reads zero after reset
    assign fb_we         = !empty;
    assign fb_addr       = empty ? 15'd0 : head[COLOR_W +: 15];
    assign fb_wdata      = empty ? '0 : head[COLOR_W-1:0];
    assign busy          = s1_valid_q || !empty;
    assign overflow      = overflow_q;
    assign clipped_count = clip_cnt_q;
endmodule

// File: tb/tb_fb_pixel_sink.sv
// Directed bench for fb_pixel_sink: clipping, dedup, FIFO fill/drain, same-cycle pop/push, async reset and clear priority.
module tb_fb_pixel_sink;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_valid;
    logic [7:0]  write_x_pos;
    logic [6:0]  write_y_pos;
    logic [2:0]  pixel_color;
    logic        fb_we;
    logic [14:0] fb_addr;
    logic [2:0]  fb_wdata;
    logic        fb_grant;
    logic        clr_status;
    logic        busy;
    logic        overflow;
    logic [15:0] clipped_count;

    int errors = 0;
    int checks = 0;
    logic [17:0] wlog[$];

    fb_pixel_sink #(.FIFO_DEPTH(16), .COLOR_W(3), .VGA_WIDTH(160), .VGA_HEIGHT(120)) dut (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .write_x_pos(write_x_pos),
        .write_y_pos(write_y_pos), .pixel_color(pixel_color), .fb_we(fb_we),
        .fb_addr(fb_addr), .fb_wdata(fb_wdata), .fb_grant(fb_grant),
        .clr_status(clr_status), .busy(busy), .overflow(overflow),
        .clipped_count(clipped_count)
    );

    always #5 clk = ~clk;

    // A write is accepted at the next rising edge; inputs are stable by the falling edge.
    always @(negedge clk) begin
        if (rst_n && fb_we && fb_grant)
            wlog.push_back({fb_wdata, fb_addr});
    end

    initial begin
        #500000;
        $display("FAIL timeout");
        $fatal(1, "bench did not finish");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input int x, input int y, input int c);
        wr_valid    = 1'b1;
        write_x_pos = 8'(x);
        write_y_pos = 7'(y);
        pixel_color = 3'(c);
        tick();
    endtask

    task automatic idle(input int n);
        wr_valid = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        rst_n = 1'b0; wr_valid = 1'b0; write_x_pos = '0; write_y_pos = '0;
        pixel_color = '0; fb_grant = 1'b1; clr_status = 1'b0;
        repeat (3) tick();
        chk("rst_fb_we", 32'(fb_we), 0);
        chk("rst_fb_addr", 32'(fb_addr), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_clipped", 32'(clipped_count), 0);
        rst_n = 1'b1;
        idle(2);

        // single beat, 2-cycle latency, 3*160+5 = 485
        beat(5, 3, 2);
        wr_valid = 1'b0;
        chk("t1_we_c1", 32'(fb_we), 0);
        chk("t1_busy_c1", 32'(busy), 1);
        tick();
        chk("t1_we_c2", 32'(fb_we), 1);
        chk("t1_addr", 32'(fb_addr), 485);
        chk("t1_wdata", 32'(fb_wdata), 2);
        chk("t1_busy_c2", 32'(busy), 1);
        tick();
        chk("t1_we_c3", 32'(fb_we), 0);
        chk("t1_busy_c3", 32'(busy), 0);
        idle(3);
        chk("t1_nwrites", 32'(wlog.size()), 1);
        chk("t1_log", 32'(wlog[0]), 32'({3'd2, 15'd485}));
        wlog.delete();

        // clipping boundary: 119*160+159 = 19199
        beat(159, 119, 5);
        beat(160, 0, 1);
        beat(0, 120, 1);
        idle(5);
        chk("t2_nwrites", 32'(wlog.size()), 1);
        chk("t2_addr", 32'(wlog[0][14:0]), 19199);
        chk("t2_clipped", 32'(clipped_count), 2);
        chk("t2_overflow", 32'(overflow), 0);
        wlog.delete();

        // duplicates: 10*160+10 = 1610
        repeat (4) beat(10, 10, 1);
        beat(10, 10, 4);
        idle(5);
        chk("t3_nwrites", 32'(wlog.size()), 2);
        chk("t3_w0", 32'(wlog[0]), 32'({3'd1, 15'd1610}));
        chk("t3_w1", 32'(wlog[1]), 32'({3'd4, 15'd1610}));
        wlog.delete();

        // 20 beats into a stalled 16-deep FIFO: addr 3200+i
        fb_grant = 1'b0;
        for (int i = 0; i < 20; i++) beat(i, 20, i % 8);
        idle(3);
        chk("t4_overflow", 32'(overflow), 1);
        chk("t4_we_stall", 32'(fb_we), 1);
        chk("t4_busy_stall", 32'(busy), 1);
        fb_grant = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("t4_drain_we", 32'(fb_we), 1);
            chk("t4_drain_addr", 32'(fb_addr), 32'(3200 + i));
            chk("t4_drain_data", 32'(fb_wdata), 32'(i % 8));
            tick();
        end
        chk("t4_we_end", 32'(fb_we), 0);
        chk("t4_busy_end", 32'(busy), 0);
        chk("t4_nwrites", 32'(wlog.size()), 16);
        wlog.delete();

        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        chk("clr_overflow", 32'(overflow), 0);
        chk("clr_clipped", 32'(clipped_count), 0);

        // full FIFO, one grant cycle while a new pixel is pushed: addr 4800+i, then 4900
        fb_grant = 1'b0;
        for (int i = 0; i < 16; i++) beat(i, 30, 3);
        idle(2);
        chk("t5_full_we", 32'(fb_we), 1);
        chk("t5_full_ovf", 32'(overflow), 0);
        beat(100, 30, 6);
        wr_valid = 1'b0;
        fb_grant = 1'b1;
        tick();
        fb_grant = 1'b0;
        chk("t5_head_after", 32'(fb_addr), 4801);
        idle(2);
        chk("t5_overflow", 32'(overflow), 0);
        fb_grant = 1'b1;
        idle(20);
        chk("t5_nwrites", 32'(wlog.size()), 17);
        for (int i = 0; i < 16; i++)
            chk("t5_order", 32'(wlog[i][14:0]), 32'(4800 + i));
        chk("t5_last", 32'(wlog[16]), 32'({3'd6, 15'd4900}));
        wlog.delete();

        // async reset mid-drain with 8 queued: addr 6400+i
        fb_grant = 1'b0;
        for (int i = 0; i < 8; i++) beat(i, 40, i);
        idle(2);
        chk("t6_we_q", 32'(fb_we), 1);
        fb_grant = 1'b1;
        tick();
        tick();
        #1 rst_n = 1'b0;
        #1;
        chk("t6_we_rst", 32'(fb_we), 0);
        chk("t6_busy_rst", 32'(busy), 0);
        chk("t6_addr_rst", 32'(fb_addr), 0);
        chk("t6_pre_writes", 32'(wlog.size()), 2);
        wlog.delete();
        tick();
        rst_n = 1'b1;
        idle(10);
        chk("t6_post_writes", 32'(wlog.size()), 0);
        chk("t6_we_post", 32'(fb_we), 0);

        // clear beats a clip event in the same cycle
        beat(200, 0, 0);
        idle(3);
        chk("t7_clip_one", 32'(clipped_count), 1);
        clr_status = 1'b1;
        beat(200, 0, 0);
        wr_valid = 1'b0;
        tick();
        clr_status = 1'b0;
        idle(2);
        chk("t7_clr_prio", 32'(clipped_count), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
